// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types for the data pair sequencer
package cv32e40p_pkg;

  // Sequencer state: IDLE issues singles and pair beat 0, SECOND issues pair beat 1
  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } seq_state_e;

  // Per-transaction type bit carried through the response-order FIFO
  typedef enum logic {
    TXN_SINGLE = 1'b0,
    TXN_PAIR   = 1'b1
  } txn_type_e;

  // Outstanding counter width; covers DEPTH up to 4
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/cv32e40p_fifo.sv
// rtl/cv32e40p_fifo.sv - small synchronous FIFO with registered storage
module cv32e40p_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage write; contents are only meaningful while counted as occupied
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cv32e40p_data_pair_sequencer.sv
// rtl/cv32e40p_data_pair_sequencer.sv - splits 64-bit core accesses into two OBI beats
module cv32e40p_data_pair_sequencer
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        core_req_i,
  input  logic        core_req64_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic        core_we64_i,
  input  logic [31:0] core_addr64_i,
  input  logic [31:0] core_wdata64_i,

  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic [31:0] core_rdata64_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        protocol_err_o
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             got_first_q;
  logic [31:0]      hold_q;
  logic             perr_q;

  logic             fifo_empty;
  logic             fifo_rdata;
  txn_type_e        head_type;
  txn_type_e        push_type;
  logic             resp_ok;
  logic             capture;
  logic             slot_free;
  logic             sel64;

  assign head_type = txn_type_e'(fifo_rdata);
  assign push_type = (state_q == SECOND) ? TXN_PAIR : TXN_SINGLE;
  assign resp_ok   = mem_rvalid_i && !fifo_empty && !rst_i;

  // Response side: singles pass straight through, pairs park beat 0 in hold_q
  always_comb begin
    core_rvalid_o  = 1'b0;
    core_rdata_o   = '0;
    core_rdata64_o = '0;
    capture        = 1'b0;
    if (resp_ok) begin
      if (head_type == TXN_SINGLE) begin
        core_rvalid_o = 1'b1;
        core_rdata_o  = mem_rdata_i;
      end else if (!got_first_q) begin
        capture = 1'b1;
      end else begin
        core_rvalid_o  = 1'b1;
        core_rdata_o   = hold_q;
        core_rdata64_o = mem_rdata_i;
      end
    end
  end

  // A response retiring this cycle frees its slot for a request in the same cycle
  assign slot_free = (cnt_q < CNT_W'(DEPTH)) || core_rvalid_o;

  // Request side: next state, memory request and core grant
  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    core_gnt_o = 1'b0;
    sel64      = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          mem_req_o = core_req_i && slot_free;
          if (mem_req_o && mem_gnt_i) begin
            if (core_req64_i) begin
              state_d = SECOND;
            end else begin
              core_gnt_o = 1'b1;
            end
          end
        end
        SECOND: begin
          mem_req_o = 1'b1;
          sel64     = 1'b1;
          if (mem_gnt_i) begin
            core_gnt_o = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_addr_o  = sel64 ? core_addr64_i  : core_addr_i;
  assign mem_we_o    = sel64 ? core_we64_i    : core_we_i;
  assign mem_wdata_o = sel64 ? core_wdata64_i : core_wdata_i;
  assign mem_be_o    = core_be_i;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outstanding transaction counter; simultaneous grant and response cancel out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      unique case ({core_gnt_o, core_rvalid_o})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Pair response tracking, first-beat hold data and sticky protocol error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      got_first_q <= 1'b0;
      hold_q      <= '0;
      perr_q      <= 1'b0;
    end else begin
      if (capture) begin
        got_first_q <= 1'b1;
        hold_q      <= mem_rdata_i;
      end else if (core_rvalid_o) begin
        got_first_q <= 1'b0;
      end
      if (mem_rvalid_i && fifo_empty) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign protocol_err_o = perr_q;

  cv32e40p_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) i_type_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (core_gnt_o),
    .data_i  (logic'(push_type)),
    .pop_i   (core_rvalid_o),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty)
  );

endmodule

// File: doc/cv32e40p_data_pair_sequencer.md
CV32E40P_DATA_PAIR_SEQUENCER -- requirements
Module: cv32e40p_data_pair_sequencer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, setting the maximum number of outstanding core transactions (legal range 1..4).
REQ-002 The module SHALL have port clk_i, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 The core-side ports SHALL be core_req_i in 1, core_req64_i in 1, core_we_i in 1, core_be_i in 4, core_addr_i in 32, core_wdata_i in 32, core_we64_i in 1, core_addr64_i in 32, core_wdata64_i in 32.
REQ-005 The core-side responses SHALL be core_gnt_o out 1, core_rvalid_o out 1, core_rdata_o out 32 (first-beat data), core_rdata64_o out 32 (second-beat data, zero for single transactions).
REQ-006 The memory-side OBI ports SHALL be mem_req_o out 1, mem_gnt_i in 1, mem_addr_o out 32, mem_we_o out 1, mem_be_o out 4, mem_wdata_o out 32, mem_rvalid_i in 1, mem_rdata_i in 32.
REQ-007 The module SHALL have port protocol_err_o, output, 1, a sticky flag set on an unexpected mem_rvalid_i.

Function
REQ-008 A single transaction (core_req_i=1, core_req64_i=0) SHALL issue one memory beat using core_addr_i/core_we_i/core_wdata_i/core_be_i.
REQ-009 A paired transaction (core_req_i=1, core_req64_i=1) SHALL issue beat 0 with core_addr_i/core_we_i/core_wdata_i, then beat 1 with core_addr64_i/core_we64_i/core_wdata64_i; both beats SHALL use core_be_i.
REQ-010 The FSM SHALL have states IDLE and SECOND; IDLE->SECOND on mem_gnt_i for beat 0 of a pair; SECOND->IDLE on mem_gnt_i for beat 1.
REQ-011 In IDLE, mem_req_o SHALL equal core_req_i combinationally (zero-latency) when the outstanding count is below DEPTH, otherwise 0.
REQ-012 In SECOND, mem_req_o SHALL be 1 regardless of the outstanding count, and the memory address/data SHALL select the 64 fields.
REQ-013 core_gnt_o SHALL equal mem_gnt_i for a single beat in IDLE, and for beat 1 in SECOND; it SHALL be 0 for beat 0 of a pair.
REQ-014 The outstanding count SHALL increment on core_gnt_o, decrement on core_rvalid_o, and hold when both occur in the same cycle.
REQ-015 A per-transaction type bit (single/pair) SHALL be pushed on core_gnt_o and popped on core_rvalid_o; responses SHALL be in order.
REQ-016 For a single transaction, core_rvalid_o SHALL equal mem_rvalid_i in the same cycle, with core_rdata_o=mem_rdata_i and core_rdata64_o=0.
REQ-017 For a pair, the first mem_rvalid_i SHALL capture mem_rdata_i into a hold register without asserting core_rvalid_o; the second SHALL assert core_rvalid_o with core_rdata_o=hold and core_rdata64_o=mem_rdata_i.
REQ-018 mem_rvalid_i with the type FIFO empty SHALL be ignored for data and SHALL set protocol_err_o until reset.
REQ-019 A grant and a response (including the last pair response) in the same cycle SHALL both be honoured without loss.

Reset
REQ-020 While rst_i=1, the FSM SHALL be IDLE, the counter 0, the FIFO empty, the hold register 0 and protocol_err_o 0.
REQ-021 Outputs derived from state SHALL be 0 in reset: core_gnt_o, core_rvalid_o, core_rdata_o, core_rdata64_o and mem_req_o.
REQ-022 Assertion of rst_i mid-pair SHALL abandon all in-flight beats; post-reset responses SHALL be flagged per REQ-018.

Structure
REQ-023 The FSM state enum and the transaction-type encoding SHALL live in cv32e40p_pkg.
REQ-024 The type FIFO SHALL be one cv32e40p_fifo instance with width 1 and depth DEPTH; the total implementation SHALL be under 400 lines.

Verification
REQ-025 Single read to 0x100 with mem_gnt_i=1 immediately and rvalid data 0xDEADBEEF one cycle later -> core_gnt_o the same cycle, core_rvalid_o=1, core_rdata_o=0xDEADBEEF, core_rdata64_o=0.
REQ-026 Paired write to 0x200/0x204 with 0x11111111/0x22222222 -> two mem beats in order, a single core_gnt_o on beat 1, and a single core_rvalid_o after the second response.
REQ-027 Paired read with responses 0xAAAA0000 then 0x0000BBBB separated by 3 idle cycles -> one core_rvalid_o with core_rdata_o=0xAAAA0000 and core_rdata64_o=0x0000BBBB.
REQ-028 DEPTH=2 with three back-to-back singles and no responses -> the third is held with mem_req_o=0; it is issued in the same cycle as the first rvalid.
REQ-029 A spurious mem_rvalid_i after reset -> protocol_err_o=1, core_rvalid_o=0.
REQ-030 rst_i pulsed while in SECOND -> next cycle IDLE, mem_req_o=0, counter 0.
